inst_fetch: RTL and testbench

Instruction fetch stage for the RV32I core. Holds the program counter, issues one word read at a time to instruction memory, and presents each returned instruction with its PC to the decode stage (control unit and register-file read) over a valid/ready handshake. It also accepts PC redirects from the execute stage, for branches and jumps, and squashes any in-flight wrong-path fetch.

---
 rtl/inst_fetch.sv | 157 +++++++++++++++
 tb/tb_inst_fetch.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch -- RV32I instruction fetch stage.
//
// Holds the program counter and issues one word read at a time to
// instruction memory. Each returned word is presented to decode together with
// its PC over a valid/ready handshake. A redirect from execute reloads the PC
// and squashes any wrong-path fetch that is still in flight.
//
// Ports:
//   iClk, iRst_n    clock, asynchronous active-low reset
//   oImem_Req       one-cycle read request (high only in the fetch state)
//   oImem_Addr      request byte address (the current PC)
//   iImem_Valid     read data valid (at least one cycle after the request)
//   iImem_Data      instruction word returned by memory
//   iRedirect       one-cycle pulse loading iRedirect_PC into the PC
//   iRedirect_PC    redirect target (low two bits ignored)
//   oInst, oInst_PC instruction and its address, registered
//   oInst_Valid     oInst/oInst_PC valid
//   iInst_Ready     decode accepts (transfer when valid and ready)
//   oFetch_Err      sticky flag: read data arrived with no request pending
// ---------------------------------------------------------------------------
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        iClk,
  input  logic        iRst_n,
  output logic        oImem_Req,
  output logic [31:0] oImem_Addr,
  input  logic        iImem_Valid,
  input  logic [31:0] iImem_Data,
  input  logic        iRedirect,
  input  logic [31:0] iRedirect_PC,
  output logic [31:0] oInst,
  output logic [31:0] oInst_PC,
  output logic        oInst_Valid,
  input  logic        iInst_Ready,
  output logic        oFetch_Err
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_HOLD
  } fetchState_t;

  fetchState_t stateReg, stateNext;
  logic [31:0] pcReg, pcNext;
  logic        discardReg, discardNext;
  logic [31:0] instReg, instNext;
  logic [31:0] instPcReg, instPcNext;
  logic        instValidReg, instValidNext;
  logic        errReg, errNext;

  logic        transfer;
  logic        unusedRedirectLsbs;

  assign transfer           = instValidReg & iInst_Ready;
  // The target is always word-aligned; its two low bits carry no information.
  assign unusedRedirectLsbs = ^iRedirect_PC[1:0];

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      stateReg     <= S_IDLE;
      pcReg        <= RESET_PC;
      discardReg   <= 1'b0;
      instReg      <= NOP;
      instPcReg    <= 32'h0000_0000;
      instValidReg <= 1'b0;
      errReg       <= 1'b0;
    end else begin
      stateReg     <= stateNext;
      pcReg        <= pcNext;
      discardReg   <= discardNext;
      instReg      <= instNext;
      instPcReg    <= instPcNext;
      instValidReg <= instValidNext;
      errReg       <= errNext;
    end
  end

  always_comb begin
    stateNext     = stateReg;
    pcNext        = pcReg;
    discardNext   = discardReg;
    instNext      = instReg;
    instPcNext    = instPcReg;
    instValidNext = instValidReg;
    // Read data is only expected while waiting; anywhere else it is a
    // protocol violation and is otherwise ignored.
    errNext       = errReg | (iImem_Valid & (stateReg != S_WAIT));

    if (iRedirect) begin
      pcNext = {iRedirect_PC[31:2], 2'b00};
      unique case (stateReg)
        S_IDLE: stateNext = S_FETCH;
        S_FETCH: begin
          // The request to the old PC is already out; its data must be dropped.
          discardNext = 1'b1;
          stateNext   = S_WAIT;
        end
        S_WAIT: begin
          if (iImem_Valid) begin
            discardNext = 1'b0;
            stateNext   = S_FETCH;
          end else begin
            discardNext = 1'b1;
          end
        end
        S_HOLD: begin
          // A transfer in this same cycle still happens; decode squashes it.
          instValidNext = 1'b0;
          stateNext     = S_FETCH;
        end
        default: stateNext = S_IDLE;
      endcase
    end else begin
      unique case (stateReg)
        S_IDLE:  stateNext = S_FETCH;
        S_FETCH: stateNext = S_WAIT;
        S_WAIT: begin
          if (iImem_Valid) begin
            if (discardReg) begin
              // Wrong-path data; PC already holds the redirect target.
              discardNext = 1'b0;
              stateNext   = S_FETCH;
            end else begin
              instNext      = iImem_Data;
              instPcNext    = pcReg;
              instValidNext = 1'b1;
              pcNext        = pcReg + 32'd4;
              stateNext     = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (transfer) begin
            instValidNext = 1'b0;
            stateNext     = S_FETCH;
          end
        end
        default: stateNext = S_IDLE;
      endcase
    end
  end

  // Request signals decode from registers only, so no input reaches them.
  assign oImem_Req   = (stateReg == S_FETCH);
  assign oImem_Addr  = pcReg;
  assign oInst       = instReg;
  assign oInst_PC    = instPcReg;
  assign oInst_Valid = instValidReg;
  assign oFetch_Err  = errReg;

endmodule

// File: tb/tb_inst_fetch.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch -- self-checking bench for inst_fetch.
//
// The bench plays instruction memory (configurable or random latency) and
// keeps a transaction-level model: which request is outstanding and whether
// it is still on the right path, which instruction is being presented to
// decode, and the address of the next instruction to fetch. The DUT outputs
// are compared with that model on every falling edge. Directed scenarios add
// literal expectations; a second instance with RESET_PC=FFFF_FFFC checks the
// PC wrap.
// ---------------------------------------------------------------------------
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rstN;
  logic        imemValid;
  logic [31:0] imemData;
  logic        redirect;
  logic [31:0] redirectPc;
  logic        ready;

  logic        req, instValid, fetchErr;
  logic [31:0] addr, inst, instPc;
  logic        req2;
  logic [31:0] addr2;
  logic [31:0] unusedInst2, unusedInstPc2;
  logic        unusedInstValid2, unusedErr2;

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .iClk(clk), .iRst_n(rstN),
    .oImem_Req(req), .oImem_Addr(addr),
    .iImem_Valid(imemValid), .iImem_Data(imemData),
    .iRedirect(redirect), .iRedirect_PC(redirectPc),
    .oInst(inst), .oInst_PC(instPc), .oInst_Valid(instValid),
    .iInst_Ready(ready), .oFetch_Err(fetchErr)
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (
    .iClk(clk), .iRst_n(rstN),
    .oImem_Req(req2), .oImem_Addr(addr2),
    .iImem_Valid(imemValid), .iImem_Data(imemData),
    .iRedirect(redirect), .iRedirect_PC(redirectPc),
    .oInst(unusedInst2), .oInst_PC(unusedInstPc2), .oInst_Valid(unusedInstValid2),
    .iInst_Ready(ready), .oFetch_Err(unusedErr2)
  );

  int checks = 0;
  int errors = 0;
  bit chkEn = 1'b0;

  // Model state
  bit          mIdle, mOut, mLive, mPres, mErr;
  logic [31:0] mOutAddr, mPresPc, mPresData, mNext;

  // Memory state
  int          memCnt;
  int          fixedLat;
  bit          randLat;
  logic [31:0] memAddr;

  // Observation logs
  logic [31:0] reqQ[$];
  int          reqCycQ[$];
  logic [31:0] req2Q[$];
  logic [31:0] xferQ[$];
  int          xferCount;
  int          cyc;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic bit expReq();
    return !mIdle && !mOut && !mPres;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mIdle = 1'b1; mOut = 1'b0; mLive = 1'b0; mPres = 1'b0; mErr = 1'b0;
    mOutAddr = 32'h0; mPresPc = 32'h0; mPresData = 32'h0000_0013;
    mNext = 32'h0000_0000;
  endtask

  // Advance the model across one rising edge using the inputs that were
  // applied during the cycle that just ended.
  task automatic modelUpdate();
    bit reqNow;
    reqNow = expReq();
    if (imemValid && !mOut) mErr = 1'b1;
    if (mPres && ready) begin
      mPres = 1'b0;
      xferCount++;
      xferQ.push_back(mPresPc);
      $display("xfer  pc=%h inst=%h", mPresPc, mPresData);
    end
    if (imemValid && mOut) begin
      if (mLive && !redirect) begin
        mPres     = 1'b1;
        mPresPc   = mOutAddr;
        mPresData = memWord(mOutAddr);
        mNext     = mOutAddr + 32'd4;
      end
      mOut = 1'b0;
    end
    if (reqNow) begin
      mOut = 1'b1; mLive = 1'b1; mOutAddr = mNext;
    end
    if (redirect) begin
      mNext = {redirectPc[31:2], 2'b00};
      mLive = 1'b0;
      mPres = 1'b0;
    end
    mIdle = 1'b0;
  endtask

  task automatic step();
    logic        sr, sr2;
    logic [31:0] sa, sa2;
    @(negedge clk);
    sr = req; sa = addr; sr2 = req2; sa2 = addr2;
    if (sr) begin
      reqQ.push_back(sa);
      reqCycQ.push_back(cyc + 1);
    end
    if (sr2) req2Q.push_back(sa2);
    @(posedge clk);
    #1;
    modelUpdate();
    if (sr) begin
      memAddr = sa;
      memCnt  = randLat ? int'($urandom_range(1, 4)) : fixedLat;
    end
    imemValid = 1'b0;
    imemData  = $urandom;
    if (memCnt > 0) begin
      memCnt--;
      if (memCnt == 0) begin
        imemValid = 1'b1;
        imemData  = memWord(memAddr);
      end
    end
    redirect = 1'b0;
    cyc++;
  endtask

  task automatic waitPres(input string name);
    for (int i = 0; i < 50; i++) begin
      if (mPres) break;
      step();
    end
    chk(name, 32'(instValid), 32'd1);
  endtask

  task automatic waitReqAfter(input string name, input int n);
    for (int i = 0; i < 50; i++) begin
      if (reqQ.size() > n) break;
      step();
    end
    if (reqQ.size() <= n) chk(name, 32'(reqQ.size()), 32'(n + 1));
  endtask

  task automatic doReset();
    rstN = 1'b0;
    modelReset();
    memCnt = 0; imemValid = 1'b0; redirect = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b1;
    cyc = 0;
    reqQ.delete(); reqCycQ.delete(); req2Q.delete(); xferQ.delete();
  endtask

  always @(negedge clk) begin
    if (chkEn) begin
      chk("req", 32'(req), 32'(expReq()));
      if (expReq()) chk("addr", addr, mNext);
      chk("inst_valid", 32'(instValid), 32'(mPres));
      chk("inst", inst, mPresData);
      chk("inst_pc", instPc, mPresPc);
      chk("fetch_err", 32'(fetchErr), 32'(mErr));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, r0, x0;
    rstN = 1'b0; imemValid = 1'b0; imemData = 32'h0; redirect = 1'b0;
    redirectPc = 32'h0; ready = 1'b1; randLat = 1'b0; fixedLat = 1;
    memCnt = 0; xferCount = 0; cyc = 0;
    doReset();
    chkEn = 1'b1;

    // Reset release, 1-cycle memory, always ready.
    repeat (12) step();
    if (reqQ.size() < 3) chk("t1_req_count", 32'(reqQ.size()), 32'd3);
    else begin
      chk("t1_req0_addr", reqQ[0], 32'h0);
      chk("t1_req1_addr", reqQ[1], 32'h4);
      chk("t1_req2_addr", reqQ[2], 32'h8);
      chk("t1_req0_cycle", 32'(reqCycQ[0]), 32'd2);
      chk("t1_req1_cycle", 32'(reqCycQ[1]), 32'd5);
      chk("t1_req2_cycle", 32'(reqCycQ[2]), 32'd8);
    end
    if (xferQ.size() < 3) chk("t1_xfer_count", 32'(xferQ.size()), 32'd3);
    else begin
      chk("t1_xfer0_pc", xferQ[0], 32'h0);
      chk("t1_xfer1_pc", xferQ[1], 32'h4);
      chk("t1_xfer2_pc", xferQ[2], 32'h8);
    end
    if (req2Q.size() < 2) chk("wrap_req_count", 32'(req2Q.size()), 32'd2);
    else begin
      chk("wrap_req0_addr", req2Q[0], 32'hFFFF_FFFC);
      chk("wrap_req1_addr", req2Q[1], 32'h0000_0000);
    end

    // Backpressure: five cycles of ready low while holding.
    ready = 1'b0;
    waitPres("t2_wait_hold");
    n0 = xferCount; r0 = reqQ.size();
    repeat (5) step();
    chk("t2_no_xfer", 32'(xferCount), 32'(n0));
    chk("t2_no_req", 32'(reqQ.size()), 32'(r0));
    ready = 1'b1;
    step();
    chk("t2_one_xfer", 32'(xferCount), 32'(n0 + 1));

    // Redirect while waiting on a 3-cycle memory.
    fixedLat = 3;
    for (int i = 0; i < 50; i++) begin
      if (mOut && memCnt == 2) break;
      step();
    end
    redirect = 1'b1; redirectPc = 32'h0000_0103;
    r0 = reqQ.size(); x0 = xferQ.size();
    step();
    waitReqAfter("t3_req_timeout", r0);
    if (reqQ.size() > r0) chk("t3_req_addr", reqQ[r0], 32'h0000_0100);
    for (int i = 0; i < 50; i++) begin
      if (xferQ.size() > x0) break;
      step();
    end
    if (xferQ.size() <= x0) chk("t3_xfer_timeout", 32'(xferQ.size()), 32'(x0 + 1));
    else chk("t3_xfer_pc", xferQ[x0], 32'h0000_0100);

    // Redirect while holding with ready low.
    fixedLat = 1; ready = 1'b0;
    waitPres("t4_wait_hold");
    x0 = xferCount; r0 = reqQ.size();
    redirect = 1'b1; redirectPc = 32'h0000_2000;
    step();
    chk("t4_valid_drop", 32'(instValid), 32'd0);
    ready = 1'b1;
    waitReqAfter("t4_req_timeout", r0);
    if (reqQ.size() > r0) chk("t4_req_addr", reqQ[r0], 32'h0000_2000);
    chk("t4_old_not_xfer", 32'(xferCount), 32'(x0));

    // Randomized traffic.
    randLat = 1'b1;
    repeat (3000) begin
      ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) begin
        redirect = 1'b1;
        redirectPc = $urandom;
      end
      step();
    end

    // Spurious read data while holding.
    randLat = 1'b0; fixedLat = 1; ready = 1'b0;
    waitPres("t5_wait_hold");
    imemValid = 1'b1; imemData = 32'hDEAD_BEEF;
    step();
    chk("t5_err_set", 32'(fetchErr), 32'd1);
    chk("t5_inst_keep", inst, memWord(mPresPc));
    repeat (3) step();
    chk("t5_err_sticky", 32'(fetchErr), 32'd1);
    rstN = 1'b0;
    modelReset();
    memCnt = 0; imemValid = 1'b0;
    #2;
    chk("t5_err_clear", 32'(fetchErr), 32'd0);
    chk("rst_valid", 32'(instValid), 32'd0);
    chk("rst_inst", inst, 32'h0000_0013);
    doReset();

    // Short randomized run after the mid-operation reset.
    randLat = 1'b1;
    repeat (500) begin
      ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 15) == 0) begin
        redirect = 1'b1;
        redirectPc = $urandom;
      end
      step();
    end

    chkEn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
